// File: rtl/ins_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ins_loader_if
//  Description : Bundle for the program loader. It carries the boot/debug byte
//                stream handshake, the instruction memory write port and the
//                CPU hold / status flags.
//  Revision    : 1.0 - initial release
//
//  Signals
//    Start      link -> loader  one-cycle pulse that begins a load
//    ByteIn     link -> loader  stream data byte
//    ByteValid  link -> loader  ByteIn valid
//    ByteReady  loader -> link  loader accepts a byte this cycle
//    WEn        loader -> imem  write enable, one pulse per word
//    WDir       loader -> imem  word-aligned byte address
//    WData      loader -> imem  instruction word
//    CpuHold    loader -> cpu   1 = CPU must stall
//    Done       loader -> link  image loaded (level)
//    Err        loader -> link  header rejected (level)
//
//  Modports
//    master : boot/debug link side (drives the stream, observes the rest)
//    slave  : the loader itself
// ============================================================================
interface ins_loader_if;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WEn;
  logic [31:0] WDir;
  logic [31:0] WData;
  logic        CpuHold;
  logic        Done;
  logic        Err;

  modport master (
    output Start, ByteIn, ByteValid,
    input  ByteReady, WEn, WDir, WData, CpuHold, Done, Err
  );

  modport slave (
    input  Start, ByteIn, ByteValid,
    output ByteReady, WEn, WDir, WData, CpuHold, Done, Err
  );
endinterface
`default_nettype wire

// File: rtl/ins_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ins_loader
//  Description : Loads a program image received as a byte stream into the
//                instruction memory. The image is a 2-byte big-endian word
//                count L followed by 4*L bytes; every 4 bytes form one
//                big-endian instruction word written at byte address 0,4,8...
//                The CPU is held until a complete image has been written.
//  Revision    : 1.0 - initial release
//
//  Ports
//    CLK   in   system clock, rising edge
//    RST   in   asynchronous active-low reset
//    bus   slave modport of ins_loader_if (stream in, imem write port out,
//          CpuHold / Done / Err status out)
//
//  Parameters
//    N_WORDS  instruction memory capacity in words (max image length)
//    CNT_W    width of the word counter
// ============================================================================
module ins_loader #(
  parameter int N_WORDS = 64,
  parameter int CNT_W   = 16
) (
  input  logic         CLK,
  input  logic         RST,
  ins_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [31:0] c_MAX_LEN = 32'(N_WORDS);

  logic [2:0]       r_state;
  logic [7:0]       r_len_hi;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_word_idx;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_asm;       // first three bytes of the word in progress
  logic [31:0]      r_wdir;
  logic [31:0]      r_wdata;

  logic             w_ready;
  logic             w_xfer;
  logic [15:0]      w_len_hdr;
  logic             w_len_bad;
  logic [CNT_W-1:0] w_word_next;
  logic [CNT_W-1:0] w_wdir_cnt;

  assign w_ready     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                       (r_state == S_DATA);
  assign w_xfer      = w_ready && bus.ByteValid;
  assign w_len_hdr   = {r_len_hi, bus.ByteIn};
  assign w_len_bad   = (w_len_hdr == 16'd0) || ({16'd0, w_len_hdr} > c_MAX_LEN);
  assign w_word_next = r_word_idx + CNT_W'(1);
  // Address is formed at counter width and zero-extended; the header check
  // keeps word_idx small enough that the shift never wraps.
  assign w_wdir_cnt  = r_word_idx << 2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_len_hi   <= 8'd0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= 2'd0;
      r_asm      <= 24'd0;
      r_wdir     <= 32'd0;
      r_wdata    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.Start) begin
            r_state    <= S_LEN_HI;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
          end
        end

        S_LEN_HI: begin
          if (w_xfer) begin
            r_len_hi <= bus.ByteIn;
            r_state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (w_xfer) begin
            r_len   <= CNT_W'(w_len_hdr);
            r_state <= w_len_bad ? S_ERR : S_DATA;
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            r_asm      <= {r_asm[15:0], bus.ByteIn};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              // Capture address and data now so they are stable throughout
              // the WRITE cycle and hold afterwards.
              r_wdata <= {r_asm, bus.ByteIn};
              r_wdir  <= 32'(w_wdir_cnt);
              r_state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          r_word_idx <= w_word_next;
          r_byte_idx <= 2'd0;
          r_state    <= (w_word_next == r_len) ? S_DONE : S_DATA;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ByteReady = w_ready;
  assign bus.WEn       = (r_state == S_WRITE);
  assign bus.WDir      = r_wdir;
  assign bus.WData     = r_wdata;
  assign bus.CpuHold   = (r_state != S_DONE);
  assign bus.Done      = (r_state == S_DONE);
  assign bus.Err       = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: doc/ins_loader.md
Name: ins_loader

Overview:
Write-side counterpart of the instruction memory read port.
- Receives a program image as a byte stream over a valid/ready handshake.
- Assembles big-endian 32-bit instruction words and writes them into instruction memory at byte addresses 0, 4, 8, …
- Holds the CPU (PC/register-write gating) until the image is complete.
- Sits between the external boot/debug link and the instruction memory write port.

Parameters:
N_WORDS, 64, instruction memory capacity in 32-bit words; maximum accepted image length.
CNT_W, 16, width of the word-count header field and internal word counter.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-low reset.
Start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
ByteIn  input  8  stream data byte.
ByteValid  input  1  ByteIn valid.
ByteReady  output  1  loader can accept a byte this cycle.
WEn  output  1  instruction memory write enable, one-cycle pulse per word.
WDir  output  32  instruction memory byte address; always word-aligned.
WData  output  32  instruction word to write.
CpuHold  output  1  1 = CPU must stall (PC frozen, no register/memory writes).
Done  output  1  image loaded successfully; level.
Err  output  1  header rejected; level.

Behaviour:
- Reset (RST=0, asynchronous):
  - State=IDLE; ByteReady=0, WEn=0, WDir=0, WData=0, Done=0, Err=0.
  - CpuHold=1. The CPU never runs before a successful load.
  - Reset mid-load aborts immediately. Words already written stay in memory and are not cleared.
- Handshake: a byte transfers on a rising CLK edge with ByteReady=1 and ByteValid=1. ByteValid while ByteReady=0 is ignored; the source must hold the byte.
- Image format: 2-byte header giving word count L (high byte first), then 4·L data bytes. Each word is big-endian: first byte goes to WData[31:24].
- FSM states:
  - IDLE: ByteReady=0. Start → LEN_HI; clears Done and Err, sets CpuHold=1, resets word and byte counters.
  - LEN_HI: ByteReady=1. Transfer latches L[15:8] → LEN_LO.
  - LEN_LO: ByteReady=1. Transfer latches L[7:0].
    - If L==0 or L>N_WORDS → ERR.
    - Otherwise → DATA.
  - DATA: ByteReady=1. Each transfer shifts the byte into the assembly register and increments byte_idx (0..3). The transfer with byte_idx==3 → WRITE.
  - WRITE (exactly one cycle): ByteReady=0, WEn=1, WDir=word_idx·4, WData=assembled word. Then word_idx increments and byte_idx clears.
    - If word_idx+1==L → DONE.
    - Otherwise → DATA.
  - DONE: ByteReady=0, Done=1, CpuHold=0.
  - ERR: ByteReady=0, Err=1, CpuHold=1.
- Start outside IDLE/DONE/ERR is ignored; no restart mid-load. Start in DONE or ERR behaves as in IDLE.
- Latency: the WEn pulse occurs the cycle after the 4th byte of a word is accepted. Sustained rate is 4 bytes per 5 cycles.
- Outside WRITE, WEn=0. WDir and WData hold their last values (no glitching).
- WDir is computed in CNT_W bits and zero-extended to 32. It wraps only if N_WORDS≥2^(CNT_W-2), which the header check prevents.
- ByteValid held high through WRITE has no effect in that cycle. The byte is accepted in the next DATA cycle.

Test Plan:
1. Reset, Start, stream 00 02 | 20 08 00 05 | AC 01 00 04 with ByteValid=1 continuously → two WEn pulses: (WDir=0, WData=0x20080005), (WDir=4, WData=0xAC010004). Then Done=1, CpuHold=0, ByteReady=0.
2. Header 00 00 → Err=1, CpuHold=1, no WEn. Header 00 41 with N_WORDS=64 → Err=1. A subsequent Start plus valid image of 1 word → Done=1, Err=0.
3. Random ByteValid gaps (pattern 1,0,0,1…) on a 3-word image → bytes accepted only on ByteReady&ByteValid. WData values exact, WDir=0,4,8. ByteReady=0 in each WRITE cycle.
4. Assert RST=0 after 6 data bytes of a 4-word image → outputs return to reset values asynchronously (before next edge), CpuHold=1. Restart and full load → Done=1, WDir sequence starts at 0.
5. Pulse Start while in DATA → ignored; load completes normally. Pulse Start in DONE → Done=0, CpuHold=1, new header accepted.
6. Full image of N_WORDS=64 words → 64 WEn pulses, last WDir=0xFC, then Done=1. Bytes offered after Done → ByteReady=0, none consumed.
